// File: rtl/wb_memresp.sv
// rtl/wb_memresp.sv - Wishbone pipelined scratch-memory responder with programmable wait states
module wb_memresp #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int LGMEMSZ       = 10,
    parameter int WAIT_STATES   = 0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wb_cyc,
    input  logic                     i_wb_stb,
    input  logic                     i_wb_we,
    input  logic [ADDRESS_WIDTH-1:0] i_wb_addr,
    input  logic [31:0]              i_wb_data,
    output logic                     o_wb_ack,
    output logic                     o_wb_stall,
    output logic                     o_wb_err,
    output logic [31:0]              o_wb_data
);

    localparam int         MEMWORDS = 1 << LGMEMSZ;
    localparam logic [2:0] WS_LOAD  = 3'(WAIT_STATES);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t             state;
    logic [2:0]         cnt;
    logic [31:0]        mem [MEMWORDS];
    logic [31:0]        hold_data;
    logic               hold_err;

    logic               accept;
    logic               in_range;
    logic [LGMEMSZ-1:0] index;
    logic [31:0]        rd_word;
    logic [31:0]        resp_word;

    assign accept    = i_wb_cyc && i_wb_stb && !o_wb_stall;
    assign in_range  = (i_wb_addr[ADDRESS_WIDTH-1:LGMEMSZ] == '0);
    assign index     = i_wb_addr[LGMEMSZ-1:0];
    assign rd_word   = mem[index];
    // Writes and bus errors return zero on the data lines.
    assign resp_word = (in_range && !i_wb_we) ? rd_word : 32'd0;

    // Storage is never cleared; a committed write survives a later abort.
    always_ff @(posedge i_clk) begin
        if (accept && in_range && i_wb_we) begin
            mem[index] <= i_wb_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            cnt        <= 3'd0;
            o_wb_ack   <= 1'b0;
            o_wb_err   <= 1'b0;
            o_wb_stall <= 1'b0;
            o_wb_data  <= 32'd0;
            hold_data  <= 32'd0;
            hold_err   <= 1'b0;
        end else if (!i_wb_cyc) begin
            // Cycle dropped: discard any pending response.
            state      <= ST_IDLE;
            cnt        <= 3'd0;
            o_wb_ack   <= 1'b0;
            o_wb_err   <= 1'b0;
            o_wb_stall <= 1'b0;
            o_wb_data  <= 32'd0;
        end else begin
            o_wb_ack  <= 1'b0;
            o_wb_err  <= 1'b0;
            o_wb_data <= 32'd0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        hold_err  <= !in_range;
                        hold_data <= resp_word;
                        if (WAIT_STATES == 0) begin
                            o_wb_ack  <= in_range;
                            o_wb_err  <= !in_range;
                            o_wb_data <= resp_word;
                        end else begin
                            state      <= ST_WAIT;
                            cnt        <= WS_LOAD;
                            o_wb_stall <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt > 3'd1) begin
                        cnt <= cnt - 3'd1;
                    end else begin
                        state      <= ST_IDLE;
                        cnt        <= 3'd0;
                        o_wb_stall <= 1'b0;
                        o_wb_ack   <= !hold_err;
                        o_wb_err   <= hold_err;
                        o_wb_data  <= hold_data;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_memresp.sv
// tb/tb_wb_memresp.sv - self-checking bench for wb_memresp over four wait-state configurations
module tb_wb_memresp;

    logic        clk;
    logic        rst;
    logic        cyc  [4];
    logic        stb  [4];
    logic        we   [4];
    logic [31:0] adr  [4];
    logic [31:0] wdat [4];
    logic        ack  [4];
    logic        stl  [4];
    logic        err  [4];
    logic [31:0] rdat [4];

    int          n_cmp;
    int          n_fail;
    logic [31:0] mdl [4][16];
    bit          vld [4][16];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        wb_memresp #(
            .ADDRESS_WIDTH(32),
            .LGMEMSZ      (10),
            .WAIT_STATES  ((g == 0) ? 0 : (g == 1) ? 3 : (g == 2) ? 4 : 5)
        ) u_dut (
            .i_clk     (clk),
            .i_rst     (rst),
            .i_wb_cyc  (cyc[g]),
            .i_wb_stb  (stb[g]),
            .i_wb_we   (we[g]),
            .i_wb_addr (adr[g]),
            .i_wb_data (wdat[g]),
            .o_wb_ack  (ack[g]),
            .o_wb_stall(stl[g]),
            .o_wb_err  (err[g]),
            .o_wb_data (rdat[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int ws_of(input int d);
        case (d)
            0:       return 0;
            1:       return 3;
            2:       return 4;
            default: return 5;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request on bus d; starts and ends at a falling edge, returns on the response cycle.
    task automatic xact(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd);
        int n;
        int ws;
        bit inr;
        int idx;
        ws  = ws_of(d);
        inr = (a[31:10] == 22'd0);
        idx = int'(a[3:0]);
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; wdat[d] = wd;
        n = 0;
        while (stl[d] !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_bound", 32'(n < 20), 32'd1);
        @(negedge clk);
        stb[d] = 1'b0;
        if (inr && w) begin
            mdl[d][idx] = wd;
            vld[d][idx] = 1'b1;
        end
        n = 0;
        while (!(ack[d] === 1'b1 || err[d] === 1'b1) && n < 20) begin
            chk("stall_in_wait", 32'(stl[d]), 32'(n < ws));
            @(negedge clk);
            n++;
        end
        chk("latency", n, ws);
        chk("ack", 32'(ack[d]), 32'(inr));
        chk("err", 32'(err[d]), 32'(!inr));
        chk("stall_at_resp", 32'(stl[d]), 32'd0);
        if (!inr) chk("err_data", rdat[d], 32'd0);
        else if (!w && vld[d][idx]) chk("rd_data", rdat[d], mdl[d][idx]);
    endtask

    task automatic idle_check(input int d);
        stb[d] = 1'b0;
        @(negedge clk);
        chk("pulse_ack", 32'(ack[d]), 32'd0);
        chk("pulse_err", 32'(err[d]), 32'd0);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b0;
        for (int d = 0; d < 4; d++) begin
            cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0; adr[d] = 32'd0; wdat[d] = 32'd0;
            for (int i = 0; i < 16; i++) begin
                vld[d][i] = 1'b0;
                mdl[d][i] = 32'd0;
            end
        end

        // Asynchronous reset before any clock edge
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 4; d++) begin
            chk("rst_ack", 32'(ack[d]), 32'd0);
            chk("rst_stall", 32'(stl[d]), 32'd0);
            chk("rst_err", 32'(err[d]), 32'd0);
            chk("rst_data", rdat[d], 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Basic write/read, no wait states
        xact(0, 1'b1, 32'd5, 32'hDEADBEEF);
        xact(0, 1'b0, 32'd5, 32'd0);
        chk("rd5_const", rdat[0], 32'hDEADBEEF);
        idle_check(0);

        // Back-to-back burst: four writes then four reads
        cyc[0] = 1'b1;
        for (int j = 0; j <= 8; j++) begin
            if (j > 0) begin
                chk("burst_ack", 32'(ack[0]), 32'd1);
                chk("burst_stall", 32'(stl[0]), 32'd0);
                if (j > 4) chk("burst_data", rdat[0], 32'h10 + 32'(j - 5));
            end
            if (j < 8) begin
                stb[0] = 1'b1; we[0] = (j < 4); adr[0] = 32'(j % 4); wdat[0] = 32'h10 + 32'(j % 4);
                if (j < 4) begin
                    mdl[0][j] = 32'h10 + 32'(j);
                    vld[0][j] = 1'b1;
                end
                @(negedge clk);
            end
        end
        idle_check(0);

        // Three wait states, strobe held through the stall window
        xact(1, 1'b1, 32'd7, 32'h55AA55AA);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 32'd7;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("ws3_stall", 32'(stl[1]), 32'd1);
            chk("ws3_noack", 32'(ack[1]), 32'd0);
            @(negedge clk);
        end
        chk("ws3_ack", 32'(ack[1]), 32'd1);
        chk("ws3_data", rdat[1], 32'h55AA55AA);
        chk("ws3_stall_low", 32'(stl[1]), 32'd0);
        @(negedge clk);
        stb[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("ws3_held_stall", 32'(stl[1]), 32'd1);
            @(negedge clk);
        end
        chk("ws3_held_ack", 32'(ack[1]), 32'd1);
        chk("ws3_held_data", rdat[1], 32'h55AA55AA);

        // Out-of-range requests produce err, memory untouched
        xact(1, 1'b1, 32'd0, 32'hA5A5A5A5);
        xact(1, 1'b0, 32'h400, 32'd0);
        xact(1, 1'b1, 32'h800, 32'h12345678);
        xact(1, 1'b0, 32'd0, 32'd0);
        chk("err_no_clobber", rdat[1], 32'hA5A5A5A5);

        // Abort two cycles after accepting a write
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 32'd9; wdat[2] = 32'h0000CAFE;
        @(negedge clk);
        stb[2] = 1'b0;
        mdl[2][9] = 32'h0000CAFE;
        vld[2][9] = 1'b1;
        chk("abort_stall1", 32'(stl[2]), 32'd1);
        @(negedge clk);
        chk("abort_stall2", 32'(stl[2]), 32'd1);
        cyc[2] = 1'b0;
        @(negedge clk);
        chk("abort_stall", 32'(stl[2]), 32'd0);
        for (int i = 0; i < 6; i++) begin
            chk("abort_ack", 32'(ack[2]), 32'd0);
            chk("abort_err", 32'(err[2]), 32'd0);
            @(negedge clk);
        end
        xact(2, 1'b0, 32'd9, 32'd0);
        chk("abort_rd9", rdat[2], 32'h0000CAFE);

        // Reset during the wait window
        xact(3, 1'b1, 32'd2, 32'h0BADF00D);
        cyc[3] = 1'b1; stb[3] = 1'b1; we[3] = 1'b0; adr[3] = 32'd2;
        @(negedge clk);
        stb[3] = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rstw_stall", 32'(stl[3]), 32'd0);
        chk("rstw_ack", 32'(ack[3]), 32'd0);
        chk("rstw_err", 32'(err[3]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            chk("rstw_no_resp", 32'(ack[3] | err[3]), 32'd0);
            @(negedge clk);
        end
        xact(3, 1'b0, 32'd2, 32'd0);
        chk("rstw_rd2", rdat[3], 32'h0BADF00D);

        // Randomized traffic against the reference model on every configuration
        for (int d = 0; d < 4; d++) begin
            for (int t = 0; t < 25; t++) begin
                logic [31:0] a;
                if ($urandom_range(0, 3) == 0) a = $urandom | 32'h400;
                else a = 32'($urandom_range(0, 15));
                xact(d, 1'($urandom_range(0, 1)), a, $urandom);
                if ($urandom_range(0, 2) == 0) idle_check(d);
            end
            idle_check(d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_memresp.md
# wb_memresp

Wishbone pipelined responder: a single-port on-chip scratch memory of 2^LGMEMSZ 32-bit words, sitting on the CPU's global or local bus as the slave end of the memory-unit master. It accepts one request per strobe and returns ack (in range) or err (out of range) after a programmable number of wait states, asserting stall while busy. It exists to exercise and serve the memory unit's single-transaction cycles, including abort and bus-error paths.

## Interface

- ADDRESS_WIDTH, 32, width of i_wb_addr (word address).
- LGMEMSZ, 10, log2 of memory depth in words; must be < ADDRESS_WIDTH.
- WAIT_STATES, 0, extra response cycles per request, legal 0..7.

- i_clk  in  1  clock; all state on rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_wb_cyc  in  1  bus cycle active.
- i_wb_stb  in  1  request strobe.
- i_wb_we  in  1  1 = write, 0 = read.
- i_wb_addr  in  ADDRESS_WIDTH  word address.
- i_wb_data  in  32  write data.
- o_wb_ack  out  1  request completed successfully.
- o_wb_stall  out  1  request not accepted this cycle.
- o_wb_err  out  1  request failed (address out of range).
- o_wb_data  out  32  read data, valid only while o_wb_ack.

## Operation

- Accept condition: i_wb_cyc && i_wb_stb && !o_wb_stall, sampled at a rising edge.
- In range: i_wb_addr[ADDRESS_WIDTH-1:LGMEMSZ] == 0; index = i_wb_addr[LGMEMSZ-1:0].
- Accepted in-range write: mem[index] <= i_wb_data at the accept edge. Later ack is unconditional; the write is not undone by a later abort.
- Accepted in-range read: mem[index] captured into a hold register at the accept edge; driven on o_wb_data with ack.
- Accepted out-of-range request: no memory access; responds with o_wb_err instead of o_wb_ack, same latency. o_wb_data is 0 in that cycle.
- States:
  - IDLE: stall=0.
  - WAIT: stall=1, 3-bit down-counter cnt active.
  - Accept in IDLE with WAIT_STATES=0: stay IDLE, ack/err next cycle.
  - Accept in IDLE with WAIT_STATES=N>0: go to WAIT, cnt=N.
  - WAIT with cnt>1: cnt--.
  - WAIT with cnt==1: return to IDLE, ack/err registered high for the next cycle.
- Abort: any edge with i_wb_cyc=0 forces state IDLE, cnt=0, next-cycle ack=err=stall=0, and drops any pending response.
- Strobes with i_wb_cyc=0 are ignored.
- ack and err are never high together and each pulses exactly one cycle per accepted request.
- Reset (async, any time, including mid-WAIT): o_wb_ack=0, o_wb_stall=0, o_wb_err=0, o_wb_data=0, state IDLE, cnt=0. Pending response is discarded.
- Memory contents are not cleared by reset; reads of unwritten words are undefined.

## Timing

- Latency: accept at edge k implies ack/err high in the cycle following edge k+WAIT_STATES, i.e. N+1 cycles after accept.
- WAIT_STATES=0: stall never asserts. Back-to-back strobes give one ack per cycle, in order.
- WAIT_STATES=N>0: stall high for the N cycles after accept and low in the ack cycle. A new request may be accepted in the ack cycle. Throughput is one request per N+1 cycles.
- Read-after-write to the same index on consecutive accepts returns the new data.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan

- Reset values, WAIT_STATES=0: assert i_rst mid-cycle without a clock edge; all outputs read 0 immediately. Release, write 0xDEADBEEF to address 5, then read address 5; ack one cycle after each strobe, o_wb_data=0xDEADBEEF, stall stays 0.
- Pipelined burst, WAIT_STATES=0: write addresses 0..3 with 0x10..0x13, then read 0..3 on consecutive strobes. Expect 4 consecutive acks returning 0x10..0x13 in order.
- Wait states, WAIT_STATES=3: read address 7 holding 0x55AA55AA. Expect stall high for 3 cycles and ack in the 4th cycle after accept. A strobe held through the stall window is accepted in the ack cycle.
- Bus error, LGMEMSZ=10: read address 0x400, then write 0x12345678 to 0x800. Expect o_wb_err for one cycle each with o_wb_ack=0. Read address 0 afterwards is unchanged.
- Abort, WAIT_STATES=4: write 0xCAFE to address 9, then drop i_wb_cyc 2 cycles later. Expect no ack/err and stall=0 the cycle after the drop. A subsequent read of address 9 returns 0xCAFE.
- Reset mid-WAIT, WAIT_STATES=5: assert i_rst 2 cycles after accept. Expect no ack/err, stall=0 immediately, and the next request served with normal latency.
